// File: rtl/uart_bus_ctrl.sv
// Memory-mapped UART controller: RX/TX byte FIFOs, TXD/RXD/UCON registers,
// a TX sequencer that feeds the bit-serial TX core, and a level interrupt.
module uart_bus_ctrl #(
  parameter int unsigned RX_DEPTH = 4,
  parameter int unsigned TX_DEPTH = 4,
  parameter logic [31:0] ADDR_TXD = 32'h4000_0018,
  parameter logic [31:0] ADDR_RXD = 32'h4000_001C,
  parameter logic [31:0] ADDR_CON = 32'h4000_0020
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic [31:0] rdata,
  input  logic [7:0]  rx_data,
  input  logic        rx_done,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  output logic        irq
);

  localparam int unsigned RX_AW = $clog2(RX_DEPTH);
  localparam int unsigned TX_AW = $clog2(TX_DEPTH);
  localparam logic [RX_AW:0] RX_CNT_MAX = (RX_AW+1)'(RX_DEPTH);
  localparam logic [TX_AW:0] TX_CNT_MAX = (TX_AW+1)'(TX_DEPTH);
  localparam logic [RX_AW:0] RX_CNT_ONE = (RX_AW+1)'(1);
  localparam logic [TX_AW:0] TX_CNT_ONE = (TX_AW+1)'(1);
  localparam logic [RX_AW-1:0] RX_PTR_ONE = RX_AW'(1);
  localparam logic [TX_AW-1:0] TX_PTR_ONE = TX_AW'(1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT_ACK, S_WAIT_DONE} tx_state_e;

  tx_state_e        state_q;
  logic [7:0]       tx_data_q;
  logic             tx_start_q;

  logic [7:0]       rx_mem_q [RX_DEPTH];
  logic [RX_AW-1:0] rx_wp_q, rx_rp_q;
  logic [RX_AW:0]   rx_cnt_q, rx_cnt_d;
  logic [7:0]       tx_mem_q [TX_DEPTH];
  logic [TX_AW-1:0] tx_wp_q, tx_rp_q;
  logic [TX_AW:0]   tx_cnt_q, tx_cnt_d;

  logic             rx_int_en_q, tx_int_en_q, tx_done_q, rx_ovf_q, irq_q;
  logic [7:0]       last_txd_q;

  logic sel_txd, sel_rxd, sel_con;
  logic rx_full, rx_nempty, tx_full, tx_nempty, tx_active;
  logic rx_pop, rx_push, rx_ovf_set, tx_push, tx_pop, tx_done_set;
  logic unused_wdata;

  assign unused_wdata = ^wdata[31:8];

  assign sel_txd = (addr == ADDR_TXD);
  assign sel_rxd = (addr == ADDR_RXD);
  assign sel_con = (addr == ADDR_CON);

  assign rx_full   = (rx_cnt_q == RX_CNT_MAX);
  assign rx_nempty = (rx_cnt_q != '0);
  assign tx_full   = (tx_cnt_q == TX_CNT_MAX);
  assign tx_nempty = (tx_cnt_q != '0);
  assign tx_active = (state_q != S_IDLE) || tx_nempty;

  // A pop in the same cycle frees the slot, so a full RX FIFO still accepts.
  assign rx_pop     = mem_read & sel_rxd & rx_nempty;
  assign rx_push    = rx_done & (~rx_full | rx_pop);
  assign rx_ovf_set = rx_done & rx_full & ~rx_pop;

  assign tx_push     = mem_write & sel_txd & ~tx_full;
  assign tx_pop      = (state_q == S_IDLE) & tx_nempty;
  assign tx_done_set = (state_q == S_WAIT_DONE) & ~tx_busy;

  always_comb begin
    rx_cnt_d = rx_cnt_q;
    if (rx_push && !rx_pop)      rx_cnt_d = rx_cnt_q + RX_CNT_ONE;
    else if (!rx_push && rx_pop) rx_cnt_d = rx_cnt_q - RX_CNT_ONE;
  end

  always_comb begin
    tx_cnt_d = tx_cnt_q;
    if (tx_push && !tx_pop)      tx_cnt_d = tx_cnt_q + TX_CNT_ONE;
    else if (!tx_push && tx_pop) tx_cnt_d = tx_cnt_q - TX_CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem_q[rx_wp_q] <= rx_data;
    if (tx_push) tx_mem_q[tx_wp_q] <= wdata[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_wp_q  <= '0;
      rx_rp_q  <= '0;
      rx_cnt_q <= '0;
      tx_wp_q  <= '0;
      tx_rp_q  <= '0;
      tx_cnt_q <= '0;
    end else begin
      if (rx_push) rx_wp_q <= rx_wp_q + RX_PTR_ONE;
      if (rx_pop)  rx_rp_q <= rx_rp_q + RX_PTR_ONE;
      if (tx_push) tx_wp_q <= tx_wp_q + TX_PTR_ONE;
      if (tx_pop)  tx_rp_q <= tx_rp_q + TX_PTR_ONE;
      rx_cnt_q <= rx_cnt_d;
      tx_cnt_q <= tx_cnt_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (tx_nempty) begin
            tx_data_q  <= tx_mem_q[tx_rp_q];
            tx_start_q <= 1'b1;
            state_q    <= S_START;
          end
        end
        S_START: begin
          tx_start_q <= 1'b0;
          state_q    <= S_WAIT_ACK;
        end
        S_WAIT_ACK:  if (tx_busy)  state_q <= S_WAIT_DONE;
        S_WAIT_DONE: if (!tx_busy) state_q <= S_IDLE;
        default:     state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_int_en_q <= 1'b0;
      tx_int_en_q <= 1'b0;
      tx_done_q   <= 1'b0;
      rx_ovf_q    <= 1'b0;
      last_txd_q  <= '0;
      irq_q       <= 1'b0;
    end else begin
      if (mem_write && sel_con) begin
        rx_int_en_q <= wdata[0];
        tx_int_en_q <= wdata[1];
      end
      if (tx_push) last_txd_q <= wdata[7:0];
      if (tx_done_set)              tx_done_q <= 1'b1;
      else if (mem_read && sel_con) tx_done_q <= 1'b0;
      if (rx_ovf_set)                           rx_ovf_q <= 1'b1;
      else if (mem_write && sel_con && wdata[5]) rx_ovf_q <= 1'b0;
      irq_q <= (rx_int_en_q & rx_nempty) | (tx_int_en_q & tx_done_q);
    end
  end

  always_comb begin
    rdata = '0;
    if (sel_txd)                rdata = {24'b0, last_txd_q};
    else if (sel_rxd && rx_nempty) rdata = {24'b0, rx_mem_q[rx_rp_q]};
    else if (sel_con)
      rdata = {24'b0, rx_full, tx_full, rx_ovf_q, tx_active,
               tx_done_q, rx_nempty, tx_int_en_q, rx_int_en_q};
  end

  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_uart_bus_ctrl.sv
// Bench for uart_bus_ctrl: queue-based reference model of the FIFOs and flags,
// plus a TX core model that holds busy for a fixed frame time.
module tb_uart_bus_ctrl;

  localparam logic [31:0] A_TXD = 32'h4000_0018;
  localparam logic [31:0] A_RXD = 32'h4000_001C;
  localparam logic [31:0] A_CON = 32'h4000_0020;
  localparam int unsigned FRAME = 20;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr, wdata, rdata;
  logic        mem_read, mem_write;
  logic [7:0]  rx_data, tx_data;
  logic        rx_done, tx_start, tx_busy, irq;

  int unsigned nvec = 0;
  int unsigned nerr = 0;
  int unsigned cyc  = 0;

  logic [7:0]  rxq[$];
  bit          ovf_m;
  logic [7:0]  sentq[$];
  int unsigned start_cyc[$];
  bit          force_busy = 1'b0;
  int unsigned busy_cnt = 0;

  uart_bus_ctrl #(
    .RX_DEPTH(4), .TX_DEPTH(4),
    .ADDR_TXD(A_TXD), .ADDR_RXD(A_RXD), .ADDR_CON(A_CON)
  ) dut (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata),
    .mem_read(mem_read), .mem_write(mem_write), .rdata(rdata),
    .rx_data(rx_data), .rx_done(rx_done), .tx_data(tx_data),
    .tx_start(tx_start), .tx_busy(tx_busy), .irq(irq)
  );

  always #5 clk = ~clk;

  // TX core: busy rises the cycle after tx_start and lasts FRAME cycles.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tx_start) begin
      sentq.push_back(tx_data);
      start_cyc.push_back(cyc);
      busy_cnt <= FRAME;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end
  end
  assign tx_busy = force_busy || (busy_cnt != 0);

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    addr = a; mem_read = 1'b1;
    #1 d = rdata;
    tick();
    mem_read = 1'b0; addr = '0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; mem_write = 1'b1;
    tick();
    mem_write = 1'b0; addr = '0; wdata = '0;
  endtask

  task automatic rx_pulse(input logic [7:0] b);
    rx_data = b; rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    if (rxq.size() < 4) rxq.push_back(b); else ovf_m = 1'b1;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    reset = 1'b1;
    repeat (3) tick();
    addr = A_CON; #1;
    nvec++; if (rdata !== 32'h0) begin nerr++; $display("FAIL reset_con_during: got %h want 0", rdata); end
    nvec++; if (tx_start !== 1'b0 || irq !== 1'b0) begin nerr++; $display("FAIL reset_outs: tx_start=%b irq=%b want 0 0", tx_start, irq); end
    reset = 1'b0; addr = '0;
    tick();
    bus_read(A_CON, d);
    nvec++; if (d !== 32'h0) begin nerr++; $display("FAIL reset_con: got %h want 0", d); end
    bus_read(A_TXD, d);
    nvec++; if (d !== 32'h0) begin nerr++; $display("FAIL reset_txd: got %h want 0", d); end
    bus_read(A_RXD, d);
    nvec++; if (d !== 32'h0) begin nerr++; $display("FAIL reset_rxd: got %h want 0", d); end
    nvec++; if (tx_data !== 8'h0 || tx_start !== 1'b0 || irq !== 1'b0) begin
      nerr++; $display("FAIL reset_idle: tx_data=%h tx_start=%b irq=%b want 00 0 0", tx_data, tx_start, irq);
    end
  endtask

  task automatic test_rx_basic;
    logic [31:0] d;
    int unsigned n;
    rx_pulse(8'h09);
    rx_pulse(8'h05);
    bus_read(A_CON, d);
    nvec++; if (d[2] !== 1'b1) begin nerr++; $display("FAIL rx_nempty: got %b want 1", d[2]); end
    bus_read(A_RXD, d);
    nvec++; if (d !== 32'h09) begin nerr++; $display("FAIL rx_first: got %h want 09", d); end
    bus_read(A_RXD, d);
    nvec++; if (d !== 32'h05) begin nerr++; $display("FAIL rx_second: got %h want 05", d); end
    void'(rxq.pop_front()); void'(rxq.pop_front());
    bus_read(A_CON, d);
    nvec++; if (d[2] !== 1'b0) begin nerr++; $display("FAIL rx_empty_flag: got %b want 0", d[2]); end
    bus_read(A_RXD, d);
    nvec++; if (d !== 32'h0) begin nerr++; $display("FAIL rx_empty_read: got %h want 0", d); end
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, 4);
      for (int k = 0; k < int'(n); k++) rx_pulse(8'($urandom));
      while (rxq.size() > 0) begin
        bus_read(A_RXD, d);
        nvec++; if (d !== {24'b0, rxq[0]}) begin nerr++; $display("FAIL rx_rand: got %h want %h", d, rxq[0]); end
        void'(rxq.pop_front());
      end
    end
  endtask

  task automatic test_rx_overflow;
    logic [31:0] d, exp;
    logic [7:0]  b;
    for (int k = 0; k < 5; k++) rx_pulse(8'h11 + 8'(k));
    bus_read(A_CON, d);
    nvec++; if (d[7] !== 1'b1 || d[5] !== 1'b1) begin nerr++; $display("FAIL ovf_flags: full=%b ovf=%b want 1 1", d[7], d[5]); end
    for (int k = 0; k < 4; k++) begin
      bus_read(A_RXD, d);
      nvec++; if (d !== 32'(8'h11 + 8'(k))) begin nerr++; $display("FAIL ovf_drain: got %h want %h", d, 8'h11 + 8'(k)); end
      void'(rxq.pop_front());
    end
    bus_read(A_CON, d);
    nvec++; if (d[5] !== 1'b1 || d[7] !== 1'b0) begin nerr++; $display("FAIL ovf_sticky: ovf=%b full=%b want 1 0", d[5], d[7]); end
    bus_write(A_CON, 32'h20); ovf_m = 1'b0;
    bus_read(A_CON, d);
    nvec++; if (d[5] !== 1'b0) begin nerr++; $display("FAIL ovf_clear: got %b want 0", d[5]); end
    for (int k = 0; k < 4; k++) rx_pulse(8'($urandom));
    // Random mix of pushes, pops and simultaneous push+pop against the queue model.
    for (int it = 0; it < 40; it++) begin
      b = 8'($urandom);
      case ($urandom_range(0, 2))
        0: rx_pulse(b);
        1: begin
          bus_read(A_RXD, d);
          exp = (rxq.size() > 0) ? {24'b0, rxq[0]} : 32'h0;
          nvec++; if (d !== exp) begin nerr++; $display("FAIL mix_pop: got %h want %h", d, exp); end
          if (rxq.size() > 0) void'(rxq.pop_front());
        end
        default: begin
          rx_data = b; rx_done = 1'b1; addr = A_RXD; mem_read = 1'b1;
          #1 d = rdata;
          tick();
          rx_done = 1'b0; mem_read = 1'b0; addr = '0;
          exp = (rxq.size() > 0) ? {24'b0, rxq[0]} : 32'h0;
          nvec++; if (d !== exp) begin nerr++; $display("FAIL mix_both: got %h want %h", d, exp); end
          if (rxq.size() > 0) void'(rxq.pop_front());
          if (rxq.size() < 4) rxq.push_back(b); else ovf_m = 1'b1;
        end
      endcase
      bus_read(A_CON, d);
      exp = {24'b0, rxq.size() == 4, 1'b0, ovf_m, 2'b00, rxq.size() != 0, 2'b00};
      nvec++; if ((d & 32'hA7) !== exp) begin nerr++; $display("FAIL mix_con: got %h want %h", d & 32'hA7, exp); end
    end
    bus_write(A_CON, 32'h20); ovf_m = 1'b0;
    while (rxq.size() > 0) begin
      bus_read(A_RXD, d);
      nvec++; if (d !== {24'b0, rxq[0]}) begin nerr++; $display("FAIL mix_drain: got %h want %h", d, rxq[0]); end
      void'(rxq.pop_front());
    end
  endtask

  task automatic wait_tx_idle(input string tag, output logic [31:0] d);
    int unsigned t = 0;
    bus_read(A_CON, d);
    while (d[4] === 1'b1 && t < 3000) begin bus_read(A_CON, d); t++; end
    nvec++; if (d[4] !== 1'b0) begin nerr++; $display("FAIL %s_timeout: tx_active=%b want 0", tag, d[4]); end
  endtask

  task automatic check_sent(input string tag, input logic [7:0] exp[$]);
    nvec++; if (sentq.size() != exp.size()) begin nerr++; $display("FAIL %s_count: got %0d want %0d", tag, sentq.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < sentq.size(); i++) begin
      nvec++; if (sentq[i] !== exp[i]) begin nerr++; $display("FAIL %s_byte%0d: got %h want %h", tag, i, sentq[i], exp[i]); end
    end
    for (int i = 1; i < start_cyc.size(); i++) begin
      nvec++; if (start_cyc[i] - start_cyc[i-1] < FRAME + 2) begin
        nerr++; $display("FAIL %s_spacing: got %0d want >=%0d", tag, start_cyc[i] - start_cyc[i-1], FRAME + 2);
      end
    end
  endtask

  task automatic test_tx_sequence;
    logic [31:0] d;
    logic [7:0]  exp[$];
    int unsigned n;
    for (int r = 0; r < 3; r++) begin
      sentq.delete(); start_cyc.delete(); exp.delete();
      if (r == 0) exp = '{8'h41, 8'h42, 8'h43};
      else begin
        n = $urandom_range(1, 4);
        for (int k = 0; k < int'(n); k++) exp.push_back(8'($urandom));
      end
      foreach (exp[k]) bus_write(A_TXD, {24'($urandom), exp[k]});
      bus_read(A_CON, d);
      nvec++; if (d[4] !== 1'b1) begin nerr++; $display("FAIL tx_active: got %b want 1", d[4]); end
      wait_tx_idle("tx_seq", d);
      nvec++; if (d[3] !== 1'b1) begin nerr++; $display("FAIL tx_done_set: got %b want 1", d[3]); end
      bus_read(A_CON, d);
      nvec++; if (d[3] !== 1'b0) begin nerr++; $display("FAIL tx_done_clear: got %b want 0", d[3]); end
      bus_read(A_TXD, d);
      nvec++; if (d !== {24'b0, exp[exp.size()-1]}) begin nerr++; $display("FAIL last_txd: got %h want %h", d, exp[exp.size()-1]); end
      check_sent("tx_seq", exp);
    end
  endtask

  task automatic test_tx_full;
    logic [31:0] d;
    logic [7:0]  b[5];
    logic [7:0]  exp[$];
    sentq.delete(); start_cyc.delete(); exp.delete();
    force_busy = 1'b1;
    exp.push_back(8'($urandom));
    bus_write(A_TXD, {24'b0, exp[0]});
    repeat (4) tick();
    for (int k = 0; k < 5; k++) begin
      b[k] = 8'($urandom);
      bus_write(A_TXD, {24'b0, b[k]});
      if (k < 4) exp.push_back(b[k]);
    end
    bus_read(A_CON, d);
    nvec++; if (d[6] !== 1'b1 || d[4] !== 1'b1) begin nerr++; $display("FAIL tx_full_flag: full=%b active=%b want 1 1", d[6], d[4]); end
    bus_read(A_TXD, d);
    nvec++; if (d !== {24'b0, b[3]}) begin nerr++; $display("FAIL tx_drop_last: got %h want %h", d, b[3]); end
    force_busy = 1'b0;
    wait_tx_idle("tx_full", d);
    check_sent("tx_full", exp);
  endtask

  task automatic test_reset_midframe;
    logic [31:0] d;
    force_busy = 1'b1;
    for (int k = 0; k < 3; k++) bus_write(A_TXD, 32'($urandom));
    repeat (4) tick();
    addr = A_CON; reset = 1'b1;
    #1;
    nvec++; if (rdata !== 32'h0) begin nerr++; $display("FAIL midframe_con: got %h want 0", rdata); end
    nvec++; if (tx_start !== 1'b0 || irq !== 1'b0) begin nerr++; $display("FAIL midframe_outs: tx_start=%b irq=%b want 0 0", tx_start, irq); end
    sentq.delete(); start_cyc.delete(); rxq.delete(); ovf_m = 1'b0;
    force_busy = 1'b0;
    repeat (2) tick();
    reset = 1'b0; addr = '0;
    repeat (60) tick();
    nvec++; if (sentq.size() != 0) begin nerr++; $display("FAIL midframe_abandon: sent %0d want 0", sentq.size()); end
    bus_read(A_CON, d);
    nvec++; if (d !== 32'h0) begin nerr++; $display("FAIL midframe_idle: got %h want 0", d); end
  endtask

  task automatic test_irq;
    logic [31:0] d;
    logic [1:0]  en;
    int unsigned t;
    bus_read(A_CON, d);
    bus_write(A_CON, 32'h3);
    tick();
    nvec++; if (irq !== 1'b0) begin nerr++; $display("FAIL irq_idle: got %b want 0", irq); end
    rx_pulse(8'h7E);
    nvec++; if (irq !== 1'b0) begin nerr++; $display("FAIL irq_lag: got %b want 0", irq); end
    tick();
    nvec++; if (irq !== 1'b1) begin nerr++; $display("FAIL irq_rx: got %b want 1", irq); end
    bus_read(A_RXD, d); void'(rxq.pop_front());
    nvec++; if (d !== 32'h7E || irq !== 1'b1) begin nerr++; $display("FAIL irq_pop: data=%h irq=%b want 7e 1", d, irq); end
    tick();
    nvec++; if (irq !== 1'b0) begin nerr++; $display("FAIL irq_rx_clear: got %b want 0", irq); end
    bus_write(A_TXD, 32'($urandom));
    t = 0;
    while (irq !== 1'b1 && t < 200) begin tick(); t++; end
    nvec++; if (irq !== 1'b1) begin nerr++; $display("FAIL irq_tx: got %b want 1", irq); end
    bus_read(A_CON, d);
    nvec++; if (d[3] !== 1'b1) begin nerr++; $display("FAIL irq_tx_done: got %b want 1", d[3]); end
    tick();
    nvec++; if (irq !== 1'b0) begin nerr++; $display("FAIL irq_tx_clear: got %b want 0", irq); end
    for (int k = 0; k < 4; k++) begin
      en = 2'($urandom);
      bus_write(A_CON, {30'($urandom), en} & 32'hFFFF_FFDF);
      bus_read(A_CON, d);
      nvec++; if (d[1:0] !== en) begin nerr++; $display("FAIL con_rw: got %b want %b", d[1:0], en); end
    end
    bus_write(A_CON, 32'h0);
  endtask

  initial begin
    addr = '0; wdata = '0; mem_read = 1'b0; mem_write = 1'b0;
    rx_data = '0; rx_done = 1'b0; reset = 1'b1; ovf_m = 1'b0;
    test_reset();
    test_rx_basic();
    test_rx_overflow();
    test_tx_sequence();
    test_tx_full();
    test_reset_midframe();
    test_irq();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/uart_bus_ctrl.md
Name: uart_bus_ctrl

Overview:
Memory-mapped UART controller between the pipeline CPU's MEM-stage peripheral bus and the existing UART RX/TX bit-serial cores.
- Buffers received bytes in an RX FIFO.
- Queues CPU-written bytes in a TX FIFO and sequences them one at a time into the TX core.
- Exposes TXD/RXD/UCON registers and drives a level interrupt toward the CPU's exception logic.

Parameters:
RX_DEPTH, 4, RX FIFO entries (power of 2, >=2)
TX_DEPTH, 4, TX FIFO entries (power of 2, >=2)
ADDR_TXD, 32'h40000018, transmit data register address
ADDR_RXD, 32'h4000001C, receive data register address
ADDR_CON, 32'h40000020, control/status register address

Ports:
clk  in  1  system clock
reset  in  1  asynchronous reset, active-high
addr  in  32  bus byte address from MEM stage
wdata  in  32  bus write data
mem_read  in  1  bus read strobe, one cycle per access
mem_write  in  1  bus write strobe, one cycle per access
rdata  out  32  read data, combinational from addr and state
rx_data  in  8  byte from RX core
rx_done  in  1  one-cycle pulse: rx_data valid
tx_data  out  8  byte to TX core
tx_start  out  1  one-cycle pulse: TX core begins frame
tx_busy  in  1  TX core busy, high from 1-2 cycles after tx_start until frame end
irq  out  1  UART interrupt request, level

Behaviour:
- Reset (async, active-high) clears all of the following. tx_start=0, tx_data=0, irq=0, rdata follows state (UCON reads 0).
  - both FIFOs empty
  - TX FSM in IDLE
  - rx_int_en=0, tx_int_en=0
  - tx_done=0, rx_ovf=0
  - last_txd=0
- A reset asserted mid-frame abandons the queued bytes. The TX core is not signalled.
- Writes take effect on the rising edge where mem_write=1. Reads are combinational. Pops and status clears from a read occur on the edge ending the mem_read cycle. Unmapped addresses read 0 and ignore writes.
- TXD write:
  - If TX FIFO not full: push wdata[7:0] and set last_txd=wdata[7:0].
  - If TX FIFO full: write dropped, last_txd unchanged.
  - TXD read returns {24'b0,last_txd}.
- RXD read:
  - If RX FIFO not empty: returns {24'b0,head} and pops.
  - If RX FIFO empty: returns 0, no pop.
- rx_done:
  - If RX FIFO not full: push rx_data.
  - If RX FIFO full: byte dropped, rx_ovf set.
  - rx_done and RXD pop in the same cycle: both occur, the count is unchanged, and the pop returns the old head. When the FIFO is full, the simultaneous pop frees the slot, so no overflow.
- UCON bits (others read 0):
  - [0] rx_int_en RW
  - [1] tx_int_en RW
  - [2] rx_not_empty RO
  - [3] tx_done sticky. Cleared by a UCON read. A set in the same cycle as a clear wins.
  - [4] tx_active RO: FSM not IDLE or TX FIFO not empty.
  - [5] rx_ovf sticky. Cleared by a UCON write with wdata[5]=1. A set in the same cycle wins.
  - [6] tx_full RO
  - [7] rx_full RO
- UCON write updates [1:0] from wdata[1:0].
- FIFO pointers: wrap modulo depth. Counts are log2(depth)+1 bits wide. Full means count==depth.
- TX FSM:
  - IDLE: if TX FIFO not empty, latch head into tx_data, pop, and go to START.
  - START: tx_start=1 for exactly this cycle, then go to WAIT_ACK.
  - WAIT_ACK: stay until tx_busy=1, then go to WAIT_DONE.
  - WAIT_DONE: stay until tx_busy=0, then set tx_done and go to IDLE.
  - Minimum spacing between consecutive tx_start pulses is frame time + 2 cycles.
  - tx_data holds its value from IDLE exit until the next load.
  - A TXD push in the same cycle IDLE pops the last entry is legal; the count stays correct.
- irq = (rx_int_en & rx_not_empty) | (tx_int_en & tx_done). It is registered, so it updates one cycle after its sources change.

Test Plan:
- Reset then UCON read -> rdata=0, tx_start=0, irq=0. Assert reset while in WAIT_DONE -> FSM IDLE, UCON=0 immediately.
- rx_done pulses with 0x09 then 0x05 (the bytes sent by the 2-frame serial stimulus) -> UCON[2]=1. RXD reads return 0x09, then 0x05, then 0x00. UCON[2]=0 after the second read.
- Five rx_done pulses (0x11..0x15) with no reads, RX_DEPTH=4 -> UCON[7]=1, UCON[5]=1, and RXD reads give 0x11..0x14. A UCON write of 0x20 clears [5]. A fifth rx_done in the same cycle as an RXD pop -> no overflow.
- Write TXD 0x41,0x42,0x43, with TX model holding busy 20 cycles per byte -> three tx_start pulses with tx_data 0x41,0x42,0x43 in order, each spaced >=22 cycles. UCON[4]=1 until the last busy falls. Then UCON[3]=1, and after a UCON read UCON[3]=0.
- Write TXD 5 times while tx_busy is held high -> the 5th write is dropped, and UCON[6]=1 once the FIFO holds 4 entries. Exactly 5 bytes are sent only if the first pop happened before the 5th write.
- Write UCON 0x3 with the RX FIFO empty -> irq=0. rx_done 0x7E -> irq=1 one cycle later. RXD read -> irq=0 one cycle after the pop.
